// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Resolves RAW hazards, taken branches and data-memory wait into PC / IF/ID / ID/EXE controls.
module pipe_hazard_ctrl #(
    parameter bit FWD_EN      = 1'b1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_src1,
    input  logic [4:0]       id_src2,
    input  logic             id_two_src,
    input  logic [4:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [4:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             hold_if,
    output logic             bubble_id,
    output logic             flush_if,
    output logic             hold_all,
    output logic [1:0]       state,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, WAIT = 2'd2, FLUSH = 2'd3} state_t;
    localparam int WC_W = MEM_TIMEOUT > 0 ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

    state_t           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic [CNT_W-1:0] stall_count_q, stall_count_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;
    logic             exe_ok, mem_ok, exe_hit, mem_hit, haz;

    // Writes to r0 are discarded, so a zero destination can never conflict
    assign exe_ok  = exe_wb_en && exe_dest != 5'd0;
    assign mem_ok  = mem_wb_en && mem_dest != 5'd0;
    assign exe_hit = exe_ok && (id_src1 == exe_dest || (id_two_src && id_src2 == exe_dest));
    assign mem_hit = mem_ok && (id_src1 == mem_dest || (id_two_src && id_src2 == mem_dest));
    assign haz     = FWD_EN ? (exe_hit && exe_mem_r_en) : (exe_hit || mem_hit);

    always_comb begin
        hold_if   = 1'b0;
        bubble_id = 1'b0;
        flush_if  = 1'b0;
        hold_all  = 1'b0;
        state_d   = RUN;
        if (!rst) begin
            state_d = RUN;
        end else if (mem_busy) begin
            hold_all = 1'b1;
            state_d  = WAIT;
        end else if (br_taken) begin
            flush_if  = 1'b1;
            bubble_id = 1'b1;
            state_d   = FLUSH;
        end else if (haz && id_valid && state_q != FLUSH) begin
            hold_if   = 1'b1;
            bubble_id = 1'b1;
            state_d   = STALL;
        end
    end

    always_comb begin
        wait_cnt_d    = mem_busy ? (wait_cnt_q == WC_MAX ? wait_cnt_q : wait_cnt_q + WC_W'(1)) : '0;
        mem_timeout_d = mem_timeout_q || (MEM_TIMEOUT != 0 && wait_cnt_d == WC_MAX);
        stall_count_d = ((hold_if || hold_all) && !(&stall_count_q)) ? stall_count_q + CNT_W'(1) : stall_count_q;
        flush_count_d = (flush_if && !(&flush_count_q)) ? flush_count_q + CNT_W'(1) : flush_count_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign state       = state_q;
    assign mem_timeout = mem_timeout_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench driving a forwarding and a non-forwarding instance in lockstep.
module tb_pipe_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst, id_valid, id_two_src, exe_wb_en, exe_mem_r_en, mem_wb_en, br_taken, mem_busy;
    logic [4:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       hif_f, bub_f, fif_f, hall_f, tmo_f, hif_n, bub_n, fif_n, hall_n, tmo_n;
    logic [1:0] st_f, st_n;
    logic [7:0] sc_f, fc_f;
    logic [1:0] sc_n, fc_n;
    int         n_cmp = 0, n_bad = 0;

    typedef struct packed {
        logic [3:0] ctl;
        logic [1:0] st;
        logic       tmo;
        logic [7:0] sc;
        logic [7:0] fc;
    } exp_t;
    exp_t sb0[$], sb1[$];
    exp_t e0, e1;

    int ms[2], mw[2], mt[2], msc[2], mfc[2];
    int fwd[2] = '{1, 0};
    int mto[2] = '{4, 0};
    int cmax[2] = '{255, 3};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FWD_EN(1'b1), .MEM_TIMEOUT(4), .CNT_W(8)) u_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .br_taken(br_taken), .mem_busy(mem_busy),
        .hold_if(hif_f), .bubble_id(bub_f), .flush_if(fif_f), .hold_all(hall_f), .state(st_f),
        .mem_timeout(tmo_f), .stall_count(sc_f), .flush_count(fc_f));

    pipe_hazard_ctrl #(.FWD_EN(1'b0), .MEM_TIMEOUT(0), .CNT_W(2)) u_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .br_taken(br_taken), .mem_busy(mem_busy),
        .hold_if(hif_n), .bubble_id(bub_n), .flush_if(fif_n), .hold_all(hall_n), .state(st_n),
        .mem_timeout(tmo_n), .stall_count(sc_n), .flush_count(fc_n));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Predict both instances for the inputs just driven, then advance the models at the edge
    task automatic step(input logic r, input logic v, input logic [4:0] s1, input logic [4:0] s2,
                        input logic two, input logic [4:0] ed, input logic ewb, input logic emr,
                        input logic [4:0] md, input logic mwb, input logic br, input logic busy);
        int nst[2], nw[2], nt[2], nsc[2], nfc[2];
        rst = r; id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
        exe_dest = ed; exe_wb_en = ewb; exe_mem_r_en = emr; mem_dest = md; mem_wb_en = mwb;
        br_taken = br; mem_busy = busy;
        for (int k = 0; k < 2; k++) begin
            logic [3:0] ctl;
            logic eh, mh, hz;
            exp_t e;
            eh = ewb && ed != 0 && (s1 == ed || (two && s2 == ed));
            mh = mwb && md != 0 && (s1 == md || (two && s2 == md));
            hz = fwd[k] != 0 ? (eh && emr) : (eh || mh);
            nst[k] = 0;
            if (!r) ctl = 4'b0000;
            else if (busy) begin ctl = 4'b0001; nst[k] = 2; end
            else if (br) begin ctl = 4'b0110; nst[k] = 3; end
            else if (hz && v && ms[k] != 3) begin ctl = 4'b1100; nst[k] = 1; end
            else ctl = 4'b0000;
            e.ctl = ctl; e.st = 2'(ms[k]); e.tmo = mt[k] != 0; e.sc = 8'(msc[k]); e.fc = 8'(mfc[k]);
            if (k == 0) sb0.push_back(e); else sb1.push_back(e);
            nsc[k] = (ctl[3] || ctl[0]) && msc[k] < cmax[k] ? msc[k] + 1 : msc[k];
            nfc[k] = ctl[1] && mfc[k] < cmax[k] ? mfc[k] + 1 : mfc[k];
            nw[k]  = busy ? (mw[k] < 1000 ? mw[k] + 1 : mw[k]) : 0;
            nt[k]  = (mt[k] != 0 || (mto[k] != 0 && nw[k] >= mto[k])) ? 1 : 0;
            if (!r) begin nst[k] = 0; nsc[k] = 0; nfc[k] = 0; nw[k] = 0; nt[k] = 0; end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            ms[k] = nst[k]; mw[k] = nw[k]; mt[k] = nt[k]; msc[k] = nsc[k]; mfc[k] = nfc[k];
        end
        #1;
    endtask

    task automatic idle(input logic r);
        step(r, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        if (sb0.size() > 0) begin
            e0 = sb0.pop_front();
            check("fwd_ctl", {28'd0, hif_f, bub_f, fif_f, hall_f}, {28'd0, e0.ctl});
            check("fwd_state", {30'd0, st_f}, {30'd0, e0.st});
            check("fwd_tmo", {31'd0, tmo_f}, {31'd0, e0.tmo});
            check("fwd_stall_cnt", {24'd0, sc_f}, {24'd0, e0.sc});
            check("fwd_flush_cnt", {24'd0, fc_f}, {24'd0, e0.fc});
        end
        if (sb1.size() > 0) begin
            e1 = sb1.pop_front();
            check("nofwd_ctl", {28'd0, hif_n, bub_n, fif_n, hall_n}, {28'd0, e1.ctl});
            check("nofwd_state", {30'd0, st_n}, {30'd0, e1.st});
            check("nofwd_tmo", {31'd0, tmo_n}, {31'd0, e1.tmo});
            check("nofwd_stall_cnt", {30'd0, sc_n}, {24'd0, e1.sc});
            check("nofwd_flush_cnt", {30'd0, fc_n}, {24'd0, e1.fc});
        end
    end

    initial begin
        for (int k = 0; k < 2; k++) begin ms[k] = 0; mw[k] = 0; mt[k] = 0; msc[k] = 0; mfc[k] = 0; end
        rst = 1'b0; id_valid = 1'b0; id_src1 = '0; id_src2 = '0; id_two_src = 1'b0; exe_dest = '0;
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; mem_dest = '0; mem_wb_en = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
        @(posedge clk); #1;
        // reset held with every request active: controls must stay low
        step(1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        idle(1'b0);
        // load-use then release
        step(1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        // r0 load, unread src2, read src2
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd1, 5'd7, 1'b0, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        // MEM-stage match held for two cycles, then invalid ID
        step(1'b1, 1'b1, 5'd9, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd9, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 5'd9, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        // branch, hazard suppressed in FLUSH, then hazard taken from RUN
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        // busy with pending branch, then branch on release
        repeat (3) step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        // busy with hazard, hazard on release
        repeat (2) step(1'b1, 1'b1, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 5'd6, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        // timeout after 4 busy cycles, sticky until reset
        repeat (6) step(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        repeat (2) idle(1'b1);
        // long stall to saturate, then reset mid-stall
        repeat (5) step(1'b1, 1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 5'd4, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) idle(1'b1);
        for (int i = 0; i < 200; i++)
            step($urandom_range(0, 24) != 0, $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0);
        @(negedge clk); #1;
        check("scoreboard_drain", 32'(sb0.size() + sb1.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
